dff_bank_arbiter: RTL and testbench
===================================

Name: dff_bank_arbiter

Overview:
- Round-robin write arbiter and sequencer for a bank of D flip-flop registers.
- Up to NREQ requesters compete for the single write path into a DEPTH x WIDTH register bank.
- One winner is served per transaction using a 3-state sequence: latch, write, acknowledge.
- A separate combinational read port exposes bank contents for observation by downstream logic and the bench.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DEPTH, 8, number of registers in the bank
- WIDTH, 8, data bits per register
- AW, 3, address width; must satisfy 2**AW >= DEPTH

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset
- req  input  NREQ  per-requester write request; held high until matching ack
- req_addr  input  NREQ*AW  flattened addresses; requester i at bits [i*AW +: AW]
- req_wdata  input  NREQ*WIDTH  flattened write data; requester i at bits [i*WIDTH +: WIDTH]
- grant  output  NREQ  one-hot; current transaction owner
- ack  output  NREQ  one-hot single-cycle completion pulse
- err  output  1  single-cycle pulse, coincident with ack; set when the latched address >= DEPTH
- busy  output  1  high whenever state != IDLE
- rd_addr  input  AW  read address
- rd_data  output  WIDTH  bank[rd_addr]; 0 when rd_addr >= DEPTH

Behaviour:
- Reset, sampled at a clk edge while reset == 0:
  - state = IDLE, rr_ptr = 0, all bank entries = 0
  - grant = 0, ack = 0, err = 0, busy = 0
  - Reset overrides every other event, including an in-flight transaction; that transaction is lost and no ack is issued.
- FSM: IDLE -> WRITE -> ACK -> IDLE. Each state lasts exactly one cycle.
- IDLE:
  - If req != 0, select the winner: the first set req bit scanning rr_ptr, rr_ptr+1, ... with wrap modulo NREQ.
  - Latch win_idx, that requester's address and data; go to WRITE.
  - Otherwise stay in IDLE.
- WRITE:
  - grant = onehot(win_idx).
  - bank[lat_addr] <= lat_data if lat_addr < DEPTH; otherwise the bank is unchanged.
  - Go to ACK.
- ACK:
  - grant held; ack = onehot(win_idx) for this cycle only.
  - err = (lat_addr >= DEPTH).
  - rr_ptr <= (win_idx + 1) mod NREQ; go to IDLE.
- Latency:
  - Request sampled in IDLE at edge N; bank updated at edge N+1; ack visible during cycle N+1..N+2.
  - Minimum 3 cycles per transaction.
  - The next arbitration happens in the IDLE cycle after ACK.
- Requester rules:
  - A requester deasserts req in the cycle after it sees ack, or re-asserts it for a new write.
  - If req stays high through IDLE, it is re-arbitrated, but at lowest priority because rr_ptr has moved past it.
- Request dropped mid-transaction: address and data are already latched, so the write and ack still complete.
- Input changes after latch: changes to req_addr/req_wdata during WRITE/ACK have no effect.
- Fairness: with all requests held high, service order is 0,1,2,3,0,...
- Read port:
  - Purely combinational from the bank registers.
  - A read of the address being written in WRITE returns the old value during that cycle and the new value from the next cycle.
- Widths:
  - rr_ptr and win_idx are ceil(log2(NREQ)) bits.
  - Wrap arithmetic is explicit modulo NREQ; NREQ need not be a power of two.

Decomposition:
- Shared package dff_bank_pkg holds:
  - FSM state encoding: IDLE = 2'd0, WRITE = 2'd1, ACK = 2'd2; 2'd3 is illegal and recovers to IDLE.
  - Default parameter constants.
- One natural sub-module: rr_pick, a combinational round-robin priority selector.
  - Inputs: req, rr_ptr.
  - Outputs: win_idx, any_req.

Test Plan:
- Reset then idle: hold reset=0 for 2 edges, release -> grant=0, ack=0, busy=0; rd_data=0 for rd_addr 0..7.
- Single write: req=4'b0010, addr1=5, data1=8'hA5 -> grant=4'b0010 in cycles 2-3; ack=4'b0010 in cycle 3 only; then rd_addr=5 gives 8'hA5; err=0.
- Fairness: req=4'b1111 held, distinct addresses 0..3 with data 8'h10..8'h13 -> acks in order 0,1,2,3,0; each ack exactly 3 cycles apart.
- Out-of-range address: DEPTH=6, addr=7, data=8'hFF -> ack and err pulse together; all bank entries unchanged.
- Reset mid-transaction: assert reset=0 during WRITE -> no ack; bank all 0; rr_ptr=0, so requester 0 wins the first arbitration after release.
- Read/write collision: write 8'h3C to address 2 while rd_addr=2 -> rd_data shows the old value 8'h00 during WRITE and 8'h3C from the ACK cycle onward.

Source files
------------

// File: rtl/dff_bank_pkg.sv
// Shared types and defaults for the register-bank write arbiter.
// State encoding is fixed; the unused code falls back to IDLE.
package dff_bank_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WRITE   = 2'd1,
      ACK     = 2'd2,
      ILLEGAL = 2'd3
   } state_t;

   localparam int NREQ_D  = 4;
   localparam int DEPTH_D = 8;
   localparam int WIDTH_D = 8;
   localparam int AW_D    = 3;

   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/dff_bank_arbiter_if.sv
// Request/ack bus and read port between requesters and the bank.
// The master drives requests and the read address.
interface dff_bank_arbiter_if
   import dff_bank_pkg::*;
#(
   parameter int NREQ  = NREQ_D,
   parameter int AW    = AW_D,
   parameter int WIDTH = WIDTH_D
);

   logic [NREQ-1:0]       req;
   logic [NREQ*AW-1:0]    req_addr;
   logic [NREQ*WIDTH-1:0] req_wdata;
   logic [NREQ-1:0]       grant;
   logic [NREQ-1:0]       ack;
   logic                  err;
   logic                  busy;
   logic [AW-1:0]         rd_addr;
   logic [WIDTH-1:0]      rd_data;

   modport master (
      output req, req_addr, req_wdata, rd_addr,
      input  grant, ack, err, busy, rd_data
   );

   modport slave (
      input  req, req_addr, req_wdata, rd_addr,
      output grant, ack, err, busy, rd_data
   );

endinterface

// File: rtl/dff_bank_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or
// after the pointer, wrapping modulo NREQ.
module rr_pick
   import dff_bank_pkg::*;
#(
   parameter int NREQ = NREQ_D,
   parameter int IW   = idx_w(NREQ_D)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IW-1:0]   i_rr_ptr,
   output logic [IW-1:0]   o_win_idx,
   output logic            o_any_req
);

   int w_idx;

   // Scan highest offset first so the nearest hit is assigned last.
   always_comb begin
      o_win_idx = '0;
      w_idx     = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         w_idx = (int'(i_rr_ptr) + k) % NREQ;
         if (i_req[w_idx]) begin
            o_win_idx = IW'(w_idx);
         end
      end
   end

   assign o_any_req = |i_req;

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin write arbiter feeding a DEPTH x WIDTH flop bank,
// one latch/write/ack sequence per winner, plus a combinational read.
module dff_bank_arbiter
   import dff_bank_pkg::*;
#(
   parameter int NREQ  = NREQ_D,
   parameter int DEPTH = DEPTH_D,
   parameter int WIDTH = WIDTH_D,
   parameter int AW    = AW_D
) (
   input  logic               clk,
   input  logic               reset,
   dff_bank_arbiter_if.slave  bus
);

   localparam int IW = idx_w(NREQ);

   state_t           r_state;
   state_t           w_next;
   logic [IW-1:0]    r_rr_ptr;
   logic [IW-1:0]    r_win_idx;
   logic [AW-1:0]    r_lat_addr;
   logic [WIDTH-1:0] r_lat_data;
   logic [WIDTH-1:0] r_bank [DEPTH];

   logic [IW-1:0]    w_pick_idx;
   logic             w_any_req;
   logic [NREQ-1:0]  w_onehot;
   logic             w_oob;

   rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_pick (
      .i_req     (bus.req),
      .i_rr_ptr  (r_rr_ptr),
      .o_win_idx (w_pick_idx),
      .o_any_req (w_any_req)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (w_any_req) w_next = WRITE;
         WRITE:   w_next = ACK;
         ACK:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_rr_ptr   <= '0;
         r_win_idx  <= '0;
         r_lat_addr <= '0;
         r_lat_data <= '0;
      end else begin
         if (r_state == IDLE && w_any_req) begin
            r_win_idx  <= w_pick_idx;
            r_lat_addr <= bus.req_addr[int'(w_pick_idx)*AW +: AW];
            r_lat_data <= bus.req_wdata[int'(w_pick_idx)*WIDTH +: WIDTH];
         end
         if (r_state == ACK) begin
            r_rr_ptr <= (r_win_idx == IW'(NREQ - 1)) ? '0
                                                     : r_win_idx + 1'b1;
         end
      end
   end

   // Out-of-range latched addresses match no entry and write nothing.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_bank[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (r_state == WRITE && r_lat_addr == AW'(i)) begin
               r_bank[i] <= r_lat_data;
            end
         end
      end
   end

   always_comb begin
      bus.rd_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (bus.rd_addr == AW'(i)) begin
            bus.rd_data = r_bank[i];
         end
      end
   end

   assign w_onehot  = NREQ'(1) << r_win_idx;
   assign w_oob     = int'(r_lat_addr) >= DEPTH;
   assign bus.grant = (r_state == WRITE || r_state == ACK) ? w_onehot
                                                            : '0;
   assign bus.ack   = (r_state == ACK) ? w_onehot : '0;
   assign bus.err   = (r_state == ACK) && w_oob;
   assign bus.busy  = (r_state != IDLE);

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed plus randomized checks of the bank arbiter against a
// transaction-level model (bank array, round-robin pointer).
module tb_dff_bank_arbiter;

   localparam int NREQ  = 4;
   localparam int DEPTH = 6;
   localparam int WIDTH = 8;
   localparam int AW    = 3;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;
   int   cyc;

   int         m_bank [8];
   int         m_ptr;
   logic [2:0] a [4];
   logic [7:0] d [4];
   int         last_ack_cyc;
   logic [3:0] ack_seen;

   dff_bank_arbiter_if #(
      .NREQ  (NREQ),
      .AW    (AW),
      .WIDTH (WIDTH)
   ) bus ();

   dff_bank_arbiter #(
      .NREQ  (NREQ),
      .DEPTH (DEPTH),
      .WIDTH (WIDTH),
      .AW    (AW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < 4; i++) begin
         bus.req_addr[i*3 +: 3]  = a[i];
         bus.req_wdata[i*8 +: 8] = d[i];
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      bus.req = '0;
      step();
      step();
      reset = 1'b1;
      for (int i = 0; i < 8; i++) m_bank[i] = 0;
      m_ptr = 0;
   endtask

   task automatic check_bank(input string tag);
      for (int i = 0; i < 8; i++) begin
         bus.rd_addr = 3'(i);
         #1;
         chk(tag, {24'd0, bus.rd_data},
             (i < DEPTH) ? m_bank[i] : 0);
      end
   endtask

   // One full transaction started from IDLE; returns observed ack.
   task automatic txn(input logic [3:0] mask,
                      input bit scramble,
                      input bit keep,
                      output logic [3:0] ack_obs);
      int         w;
      int         la;
      logic [7:0] ld;
      int         old;
      bus.req = mask;
      drive_inputs();
      w = -1;
      for (int k = 0; k < 4; k++) begin
         if (w < 0 && mask[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
      end
      la = int'(a[w]);
      ld = d[w];
      step();
      chk("grant_wr", {28'd0, bus.grant}, 32'(1 << w));
      chk("ack_wr", {28'd0, bus.ack}, 0);
      chk("busy_wr", {31'd0, bus.busy}, 1);
      old = (la < DEPTH) ? m_bank[la] : 0;
      bus.rd_addr = 3'(la);
      #1;
      chk("rd_old", {24'd0, bus.rd_data}, 32'(old));
      if (scramble) begin
         bus.req_addr  = 12'($urandom);
         bus.req_wdata = $urandom;
         if (!keep) bus.req = '0;
      end
      step();
      ack_obs = bus.ack;
      chk("ack", {28'd0, bus.ack}, 32'(1 << w));
      chk("grant_ack", {28'd0, bus.grant}, 32'(1 << w));
      chk("err", {31'd0, bus.err}, (la >= DEPTH) ? 1 : 0);
      if (la < DEPTH) m_bank[la] = int'(ld);
      chk("rd_new", {24'd0, bus.rd_data},
          32'((la < DEPTH) ? m_bank[la] : 0));
      m_ptr = (w + 1) % 4;
      last_ack_cyc = cyc;
      if (!keep) bus.req = '0;
      step();
      chk("busy_idle", {31'd0, bus.busy}, 0);
      chk("ack_idle", {28'd0, bus.ack}, 0);
      chk("grant_idle", {28'd0, bus.grant}, 0);
   endtask

   initial begin
      int         prev;
      logic [3:0] m;
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      bus.req = '0;
      bus.rd_addr = '0;
      for (int i = 0; i < 4; i++) begin
         a[i] = '0;
         d[i] = '0;
      end
      drive_inputs();

      do_reset();
      chk("rst_grant", {28'd0, bus.grant}, 0);
      chk("rst_ack", {28'd0, bus.ack}, 0);
      chk("rst_busy", {31'd0, bus.busy}, 0);
      chk("rst_err", {31'd0, bus.err}, 0);
      check_bank("rst_bank");

      a[1] = 3'd5;
      d[1] = 8'hA5;
      txn(4'b0010, 1'b0, 1'b0, ack_seen);
      bus.rd_addr = 3'd5;
      #1;
      chk("single_rd", {24'd0, bus.rd_data}, 32'h A5);

      a[0] = 3'd2;
      d[0] = 8'h3C;
      txn(4'b0001, 1'b0, 1'b0, ack_seen);
      check_bank("coll_bank");

      do_reset();
      for (int i = 0; i < 4; i++) begin
         a[i] = 3'(i);
         d[i] = 8'h10 + 8'(i);
      end
      prev = -1;
      for (int k = 0; k < 5; k++) begin
         txn(4'b1111, 1'b0, 1'b1, ack_seen);
         chk("fair_order", {28'd0, ack_seen}, 32'(1 << (k % 4)));
         if (prev >= 0) chk("fair_gap", 32'(last_ack_cyc - prev), 3);
         prev = last_ack_cyc;
      end
      bus.req = '0;
      step();
      check_bank("fair_bank");

      a[2] = 3'd7;
      d[2] = 8'hFF;
      txn(4'b0100, 1'b0, 1'b0, ack_seen);
      a[3] = 3'd6;
      d[3] = 8'hEE;
      txn(4'b1000, 1'b1, 1'b0, ack_seen);
      check_bank("oob_bank");

      for (int t = 0; t < 40; t++) begin
         m = 4'($urandom_range(1, 15));
         for (int i = 0; i < 4; i++) begin
            a[i] = 3'($urandom);
            d[i] = 8'($urandom);
         end
         txn(m, 1'($urandom), 1'($urandom), ack_seen);
      end
      bus.req = '0;
      step();
      check_bank("rand_bank");

      a[2] = 3'd1;
      d[2] = 8'h55;
      bus.req = 4'b0100;
      drive_inputs();
      step();
      chk("mid_busy", {31'd0, bus.busy}, 1);
      reset = 1'b0;
      bus.req = '0;
      step();
      chk("mid_ack", {28'd0, bus.ack}, 0);
      chk("mid_grant", {28'd0, bus.grant}, 0);
      step();
      reset = 1'b1;
      for (int i = 0; i < 8; i++) m_bank[i] = 0;
      m_ptr = 0;
      check_bank("mid_bank");
      for (int i = 0; i < 4; i++) begin
         a[i] = 3'(i + 1);
         d[i] = 8'h80 + 8'(i);
      end
      txn(4'b1111, 1'b0, 1'b0, ack_seen);
      chk("mid_winner", {28'd0, ack_seen}, 32'h1);
      check_bank("final_bank");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
